// File: rtl/mem_pkg.sv
// Shared types and encodings for the MIPS memory stage.
// Pure definitions: no logic, no timing.
package mem_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  // Execute-to-memory pipeline register contents; PC+8 is precomputed so reset/flush give 0.
  typedef struct packed {
    logic              jump;
    logic              regwrite;
    logic              memwrite;
    logic              memread;
    logic [1:0]        size;
    logic              sgn;
    logic [2:0]        memtoreg;
    logic [4:0]        wreg;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] pc8;
  } mreg_t;

endpackage

// File: rtl/data_ram_be.sv
// Word-organised data RAM: combinational read, byte-enable write at the clock edge.
// Contents are never reset; a zero byte-enable leaves the array untouched.
module data_ram_be
  import mem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_stage.sv
// MIPS M stage: E->M register, data RAM with sized loads/stores, misalignment check.
// Each memory op occupies M for 1+WAIT_CYCLES cycles, holding stallM high for all but the last.
module mem_stage
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flushM,
  input  logic              jumpE,
  input  logic              RegWriteE,
  input  logic              MemWriteE,
  input  logic              MemReadE,
  input  logic [1:0]        MemSizeE,
  input  logic              MemSignedE,
  input  logic [2:0]        MemtoRegE,
  input  logic [4:0]        WriteRegE,
  input  logic [DATA_W-1:0] ALUOutE,
  input  logic [DATA_W-1:0] WriteDataE,
  input  logic [DATA_W-1:0] PCPlus4E,
  output logic              jumpM,
  output logic              RegWriteM,
  output logic [2:0]        MemtoRegM,
  output logic [4:0]        WriteRegM,
  output logic [DATA_W-1:0] ALUOutM,
  output logic [DATA_W-1:0] PCPlus8M,
  output logic [DATA_W-1:0] ReadDataM,
  output logic              stallM,
  output logic              misalignM
);

  localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);

  mreg_t             m_q, m_d, e_in;
  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              mem_access, mem_op, store_commit;
  logic [1:0]        lane;
  logic [3:0]        lane_be, ram_be;
  logic [DATA_W-1:0] ram_rdata, lane_data, load_ext, wdata_rep;

  assign e_in = '{jump: jumpE, regwrite: RegWriteE, memwrite: MemWriteE, memread: MemReadE,
                  size: MemSizeE, sgn: MemSignedE, memtoreg: MemtoRegE, wreg: WriteRegE,
                  alu: ALUOutE, wdata: WriteDataE, pc8: PCPlus4E + 32'd4};

  always_comb begin
    m_d = m_q;
    if (flushM) begin
      m_d = '0;
    end else if (!stallM) begin
      m_d = e_in;
    end
  end

  always_comb begin
    mem_access = m_q.memread | m_q.memwrite;
    misalignM  = mem_access & (((m_q.size == MEM_HALF) & m_q.alu[0]) |
                               (m_q.size[1] & (|m_q.alu[1:0])));
    mem_op     = mem_access & ~misalignM;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stallM  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_op && (WAIT_L != 4'd0)) begin
          stallM  = 1'b1;
          state_d = S_WAIT;
          cnt_d   = 4'd1;
        end
      end
      S_WAIT: begin
        stallM = (cnt_q < WAIT_L);
        if (stallM) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    if (flushM) begin
      state_d = S_IDLE;
      cnt_d   = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_q     <= '0;
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      m_q     <= m_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Little-endian lanes: shift the addressed byte/half down to bit 0 before extending.
  always_comb begin
    lane      = m_q.alu[1:0];
    lane_data = ram_rdata >> {lane, 3'b000};
    case (m_q.size)
      MEM_BYTE: begin
        load_ext  = m_q.sgn ? {{24{lane_data[7]}}, lane_data[7:0]} : {24'd0, lane_data[7:0]};
        lane_be   = 4'b0001 << lane;
        wdata_rep = {4{m_q.wdata[7:0]}};
      end
      MEM_HALF: begin
        load_ext  = m_q.sgn ? {{16{lane_data[15]}}, lane_data[15:0]} : {16'd0, lane_data[15:0]};
        lane_be   = lane[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{m_q.wdata[15:0]}};
      end
      default: begin
        load_ext  = ram_rdata;
        lane_be   = 4'b1111;
        wdata_rep = m_q.wdata;
      end
    endcase
    store_commit = m_q.memwrite & mem_op & ~stallM & ~flushM & ~rst;
    ram_be       = store_commit ? lane_be : 4'b0000;
    ReadDataM    = (m_q.memread & mem_op) ? load_ext : '0;
  end

  data_ram_be #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .be    (ram_be),
    .addr  (m_q.alu[ADDR_W+1:2]),
    .wdata (wdata_rep),
    .rdata (ram_rdata)
  );

  assign jumpM     = m_q.jump;
  assign RegWriteM = m_q.regwrite & ~misalignM;
  assign MemtoRegM = m_q.memtoreg;
  assign WriteRegM = m_q.wreg;
  assign ALUOutM   = m_q.alu;
  assign PCPlus8M  = m_q.pc8;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: a zero-wait and a three-wait instance share E inputs,
// each checked against its own byte-array memory model.
module tb_mem_stage;
  import mem_pkg::*;

  localparam int AW     = 6;
  localparam int NBYTES = 4 << AW;

  logic clk = 1'b0;
  logic rst, flush0, flush3;
  logic jumpE, RegWriteE, MemWriteE, MemReadE, MemSignedE;
  logic [1:0]  MemSizeE;
  logic [2:0]  MemtoRegE;
  logic [4:0]  WriteRegE;
  logic [31:0] ALUOutE, WriteDataE, PCPlus4E;

  logic        jumpM0, RegWriteM0, stallM0, misalignM0;
  logic [2:0]  MemtoRegM0;
  logic [4:0]  WriteRegM0;
  logic [31:0] ALUOutM0, PCPlus8M0, ReadDataM0;
  logic        jumpM3, RegWriteM3, stallM3, misalignM3;
  logic [2:0]  MemtoRegM3;
  logic [4:0]  WriteRegM3;
  logic [31:0] ALUOutM3, PCPlus8M3, ReadDataM3;

  int tests = 0;
  int fails = 0;
  logic [7:0] mdl [2][NBYTES];

  always #5 clk = ~clk;

  mem_stage #(.ADDR_W(AW), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .flushM(flush0), .jumpE(jumpE), .RegWriteE(RegWriteE),
    .MemWriteE(MemWriteE), .MemReadE(MemReadE), .MemSizeE(MemSizeE), .MemSignedE(MemSignedE),
    .MemtoRegE(MemtoRegE), .WriteRegE(WriteRegE), .ALUOutE(ALUOutE), .WriteDataE(WriteDataE),
    .PCPlus4E(PCPlus4E), .jumpM(jumpM0), .RegWriteM(RegWriteM0), .MemtoRegM(MemtoRegM0),
    .WriteRegM(WriteRegM0), .ALUOutM(ALUOutM0), .PCPlus8M(PCPlus8M0), .ReadDataM(ReadDataM0),
    .stallM(stallM0), .misalignM(misalignM0)
  );

  mem_stage #(.ADDR_W(AW), .WAIT_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .flushM(flush3), .jumpE(jumpE), .RegWriteE(RegWriteE),
    .MemWriteE(MemWriteE), .MemReadE(MemReadE), .MemSizeE(MemSizeE), .MemSignedE(MemSignedE),
    .MemtoRegE(MemtoRegE), .WriteRegE(WriteRegE), .ALUOutE(ALUOutE), .WriteDataE(WriteDataE),
    .PCPlus4E(PCPlus4E), .jumpM(jumpM3), .RegWriteM(RegWriteM3), .MemtoRegM(MemtoRegM3),
    .WriteRegM(WriteRegM3), .ALUOutM(ALUOutM3), .PCPlus8M(PCPlus8M3), .ReadDataM(ReadDataM3),
    .stallM(stallM3), .misalignM(misalignM3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic misal(input logic [31:0] a, input logic [1:0] sz);
    return (a % nbytes(sz)) != 0;
  endfunction

  function automatic logic [31:0] mdl_load(input int d, input logic [31:0] a,
                                           input logic [1:0] sz, input logic sg);
    int b = int'(a % NBYTES);
    int n = nbytes(sz);
    logic [31:0] v = 32'd0;
    for (int i = n - 1; i >= 0; i--) v = (v << 8) | 32'(mdl[d][b + i]);
    if (sg && n < 4 && v[8*n-1]) v = v - (32'd1 << (8*n));
    return v;
  endfunction

  task automatic model_store(input int d, input logic [31:0] a, input logic [1:0] sz,
                             input logic [31:0] wd);
    int b = int'(a % NBYTES);
    for (int i = 0; i < nbytes(sz); i++) mdl[d][b + i] = wd[8*i +: 8];
  endtask

  task automatic drive(input logic mr, input logic mw, input logic [1:0] sz, input logic sg,
                       input logic rw, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] pc);
    MemReadE   = mr;
    MemWriteE  = mw;
    MemSizeE   = sz;
    MemSignedE = sg;
    RegWriteE  = rw;
    ALUOutE    = a;
    WriteDataE = wd;
    PCPlus4E   = pc;
    jumpE      = 1'($urandom);
    MemtoRegE  = 3'($urandom);
    WriteRegE  = 5'($urandom);
  endtask

  task automatic nop();
    drive(1'b0, 1'b0, MEM_BYTE, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
  endtask

  // Called just after a negedge with both instances ready; returns there once u3 is done.
  task automatic do_op(input logic mr, input logic mw, input logic [1:0] sz, input logic sg,
                       input logic rw, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] pc, output logic [31:0] rd0, output logic [31:0] rd3);
    logic        mis, is_mem;
    logic [31:0] exp_rd;
    int          st;
    drive(mr, mw, sz, sg, rw, a, wd, pc);
    mis    = (mr | mw) & misal(a, sz);
    is_mem = (mr | mw) & ~mis;
    @(posedge clk);
    @(negedge clk);
    exp_rd = (mr && !mis) ? mdl_load(0, a, sz, sg) : 32'd0;
    chk("rdata0", ReadDataM0, exp_rd);
    chk("misalign0", 32'(misalignM0), 32'(mis));
    chk("regwrite0", 32'(RegWriteM0), 32'(rw & ~mis));
    chk("stall0", 32'(stallM0), 32'd0);
    chk("pc8_0", PCPlus8M0, pc + 32'd4);
    chk("alu0", ALUOutM0, a);
    chk("wreg0", 32'(WriteRegM0), 32'(WriteRegE));
    chk("mtr0", 32'(MemtoRegM0), 32'(MemtoRegE));
    chk("jump0", 32'(jumpM0), 32'(jumpE));
    rd0 = ReadDataM0;
    if (mw && !mis) model_store(0, a, sz, wd);
    st = 0;
    while (stallM3 !== 1'b0 && st < 20) begin
      st++;
      @(negedge clk);
    end
    chk("stall3_cycles", 32'(st), is_mem ? 32'd3 : 32'd0);
    exp_rd = (mr && !mis) ? mdl_load(1, a, sz, sg) : 32'd0;
    chk("rdata3", ReadDataM3, exp_rd);
    chk("misalign3", 32'(misalignM3), 32'(mis));
    chk("regwrite3", 32'(RegWriteM3), 32'(rw & ~mis));
    chk("pc8_3", PCPlus8M3, pc + 32'd4);
    chk("alu3", ALUOutM3, a);
    chk("wreg3", 32'(WriteRegM3), 32'(WriteRegE));
    rd3 = ReadDataM3;
    if (mw && !mis) model_store(1, a, sz, wd);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_out0"}, {jumpM0, RegWriteM0, stallM0, misalignM0, 3'd0, MemtoRegM0, 3'd0, WriteRegM0, 16'd0}, 32'd0);
    chk({tag, "_alu0"}, ALUOutM0, 32'd0);
    chk({tag, "_pc8_0"}, PCPlus8M0, 32'd0);
    chk({tag, "_rd0"}, ReadDataM0, 32'd0);
    chk({tag, "_out3"}, {jumpM3, RegWriteM3, stallM3, misalignM3, 3'd0, MemtoRegM3, 3'd0, WriteRegM3, 16'd0}, 32'd0);
    chk({tag, "_alu3"}, ALUOutM3, 32'd0);
    chk({tag, "_pc8_3"}, PCPlus8M3, 32'd0);
    chk({tag, "_rd3"}, ReadDataM3, 32'd0);
    chk({tag, "_state3"}, 32'(u3.state_q), 32'(S_IDLE));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    logic [31:0] r0, r3;
    logic [1:0]  sz;
    logic        mr, mw;
    int          kind;
    logic [31:0] a;

    rst    = 1'b1;
    flush0 = 1'b0;
    flush3 = 1'b0;
    drive(1'b1, 1'b0, MEM_WORD, 1'b1, 1'b1, 32'h0000_0042, 32'h1234_5678, 32'hFFFF_FFFC);
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;

    for (int i = 0; i < (1 << AW); i++)
      do_op(1'b0, 1'b1, MEM_WORD, 1'b0, 1'b0, 32'(i * 4), $urandom, $urandom, r0, r3);

    do_op(1'b0, 1'b1, MEM_WORD, 1'b0, 1'b0, 32'h40, 32'hDEAD_BEEF, 32'h100, r0, r3);
    do_op(1'b1, 1'b0, MEM_WORD, 1'b0, 1'b1, 32'h40, 32'd0, 32'h104, r0, r3);
    chk("lw_0x40", r0, 32'hDEAD_BEEF);
    do_op(1'b1, 1'b0, MEM_WORD, 1'b0, 1'b1, 32'h1040, 32'd0, 32'h108, r0, r3);
    chk("lw_wrap", r3, 32'hDEAD_BEEF);

    do_op(1'b0, 1'b1, MEM_WORD, 1'b0, 1'b0, 32'h80, 32'h80FF_7F01, 32'h200, r0, r3);
    do_op(1'b1, 1'b0, MEM_BYTE, 1'b1, 1'b1, 32'h81, 32'd0, 32'h204, r0, r3);
    chk("lb_0x81", r0, 32'h0000_007F);
    do_op(1'b1, 1'b0, MEM_BYTE, 1'b1, 1'b1, 32'h82, 32'd0, 32'h208, r0, r3);
    chk("lb_0x82", r0, 32'hFFFF_FFFF);
    do_op(1'b1, 1'b0, MEM_BYTE, 1'b0, 1'b1, 32'h83, 32'd0, 32'h20C, r0, r3);
    chk("lbu_0x83", r0, 32'h0000_0080);
    do_op(1'b1, 1'b0, MEM_HALF, 1'b1, 1'b1, 32'h82, 32'd0, 32'h210, r0, r3);
    chk("lh_0x82", r0, 32'hFFFF_80FF);

    // sb with waits: RAM word 1 must only change after the fourth M cycle
    do_op(1'b0, 1'b1, MEM_WORD, 1'b0, 1'b0, 32'h04, 32'd0, 32'h300, r0, r3);
    drive(1'b0, 1'b1, MEM_BYTE, 1'b0, 1'b0, 32'h05, 32'h1234_56AA, 32'h304);
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("sb_stall", 32'(stallM3), (k < 3) ? 32'd1 : 32'd0);
      chk("sb_ram_pre", u3.u_ram.mem_q[1], 32'd0);
    end
    nop();
    @(posedge clk);
    @(negedge clk);
    chk("sb_ram_post", u3.u_ram.mem_q[1], 32'h0000_AA00);
    model_store(0, 32'h05, MEM_BYTE, 32'h1234_56AA);
    model_store(1, 32'h05, MEM_BYTE, 32'h1234_56AA);
    do_op(1'b1, 1'b0, MEM_WORD, 1'b0, 1'b1, 32'h04, 32'd0, 32'h308, r0, r3);
    chk("lw_after_sb", r3, 32'h0000_AA00);

    // flush of a store while waiting with cnt=2
    do_op(1'b0, 1'b1, MEM_WORD, 1'b0, 1'b0, 32'h20, 32'h1111_1111, 32'h400, r0, r3);
    drive(1'b0, 1'b1, MEM_WORD, 1'b0, 1'b1, 32'h20, 32'hCAFE_F00D, 32'h404);
    @(posedge clk);
    repeat (3) @(negedge clk);
    chk("flush_cnt", 32'(u3.cnt_q), 32'd2);
    chk("flush_state_wait", 32'(u3.state_q), 32'(S_WAIT));
    flush3 = 1'b1;
    nop();
    @(posedge clk);
    @(negedge clk);
    flush3 = 1'b0;
    chk("flush_stall", 32'(stallM3), 32'd0);
    chk("flush_state", 32'(u3.state_q), 32'(S_IDLE));
    chk("flush_regwrite", 32'(RegWriteM3), 32'd0);
    chk("flush_ram", u3.u_ram.mem_q[8], 32'h1111_1111);
    model_store(0, 32'h20, MEM_WORD, 32'hCAFE_F00D);
    do_op(1'b1, 1'b0, MEM_WORD, 1'b0, 1'b1, 32'h20, 32'd0, 32'h408, r0, r3);
    chk("lw_after_flush", r3, 32'h1111_1111);

    // misaligned accesses: no stall, no regwrite, no store
    do_op(1'b1, 1'b0, MEM_WORD, 1'b0, 1'b1, 32'h42, 32'd0, 32'h500, r0, r3);
    do_op(1'b0, 1'b1, MEM_HALF, 1'b0, 1'b0, 32'h43, 32'hFFFF_FFFF, 32'h504, r0, r3);
    do_op(1'b1, 1'b0, MEM_WORD, 1'b0, 1'b1, 32'h40, 32'd0, 32'h508, r0, r3);
    chk("sh_mis_ram", r3, 32'hDEAD_BEEF);

    // reset in the middle of a waited store
    drive(1'b0, 1'b1, MEM_WORD, 1'b0, 1'b1, 32'h24, 32'h5A5A_5A5A, 32'hFFFF_FFFC);
    @(posedge clk);
    @(negedge clk);
    model_store(0, 32'h24, MEM_WORD, 32'h5A5A_5A5A);
    @(negedge clk);
    chk("rst_state_wait", 32'(u3.state_q), 32'(S_WAIT));
    rst = 1'b1;
    nop();
    @(posedge clk);
    @(negedge clk);
    chk_reset("midrst");
    rst = 1'b0;
    do_op(1'b0, 1'b0, MEM_BYTE, 1'b0, 1'b1, 32'h1234, 32'd0, 32'hFFFF_FFFC, r0, r3);
    chk("pc8_wrap", PCPlus8M3, 32'h0000_0000);
    do_op(1'b1, 1'b0, MEM_WORD, 1'b0, 1'b1, 32'h24, 32'd0, 32'h600, r0, r3);
    chk("lw_after_rst", r0, 32'h5A5A_5A5A);

    for (int i = 0; i < 80; i++) begin
      kind = int'($urandom_range(0, 2));
      mr   = (kind == 0);
      mw   = (kind == 1);
      sz   = 2'($urandom_range(0, 3));
      a    = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~32'(nbytes(sz) - 1);
      do_op(mr, mw, sz, 1'($urandom), 1'($urandom), a, $urandom, $urandom, r0, r3);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
